// File: rtl/trace_sequencer.sv
// In-order per-instruction stage-timing sequencer: tracks each fetched instruction
// through IF/ID/EX/WB, timestamps every stage boundary and emits records in program order.
module trace_sequencer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TS_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    trace_en,
  input  logic                    flush,
  input  logic                    if_start,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_end,
  input  logic [DATA_WIDTH-1:0]   if_instr,
  input  logic                    id_end,
  input  logic                    ex_end,
  input  logic                    ex_pass_through,
  input  logic                    wb_end,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [ADDR_WIDTH-1:0]   trace_addr,
  output logic [DATA_WIDTH-1:0]   trace_instr,
  output logic                    trace_pass_through,
  output logic [8*TS_WIDTH-1:0]   trace_ts,
  output logic                    overflow,
  output logic                    proto_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IF_S = 0, IF_E = 1, ID_S = 2, ID_E = 3, EX_S = 4, EX_E = 5, WB_S = 6, WB_E = 7;

  typedef enum logic [2:0] {S_FREE, S_FETCH, S_DECODE, S_EXEC, S_WBACK, S_DONE} entry_state_e;
  typedef logic [PW-1:0] ptr_t;

  entry_state_e            st_q [DEPTH];
  entry_state_e            st_d [DEPTH];
  logic [ADDR_WIDTH-1:0]   addr_q  [DEPTH];
  logic [DATA_WIDTH-1:0]   instr_q [DEPTH];
  logic                    pt_q    [DEPTH];
  logic [TS_WIDTH-1:0]     ts_q    [DEPTH][8];
  logic [TS_WIDTH-1:0]     cnt_q;

  ptr_t alloc_ptr, ifq_ptr, idq_ptr, exq_ptr, head_ptr, wbq_ptr, scan_ptr;
  logic full, pop, wb_found;
  logic do_alloc, do_if, do_id, do_ex, do_wb;

  // Every decision below looks only at start-of-cycle entry state, so an entry
  // touched this cycle cannot also be the target of its next stage event.
  assign trace_valid = (st_q[head_ptr] == S_DONE);
  assign pop         = trace_valid & trace_ready & ~flush;
  assign full        = (st_q[alloc_ptr] != S_FREE);
  assign do_alloc    = if_start & trace_en & ~flush & (~full | pop);
  assign do_if       = if_end & ~flush & (st_q[ifq_ptr] == S_FETCH);
  assign do_id       = id_end & ~flush & (st_q[idq_ptr] == S_DECODE);
  assign do_ex       = ex_end & ~flush & (st_q[exq_ptr] == S_EXEC);
  assign do_wb       = wb_end & ~flush & wb_found;

  // Pass-through entries never enter WBACK, so the oldest WBACK entry is found by
  // scanning forward from the head.
  always_comb begin
    wbq_ptr  = head_ptr;
    wb_found = 1'b0;
    scan_ptr = head_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      scan_ptr = head_ptr + ptr_t'(i);
      if (!wb_found && st_q[scan_ptr] == S_WBACK) begin
        wbq_ptr  = scan_ptr;
        wb_found = 1'b1;
      end
    end
  end

  always_comb begin
    st_d = st_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) st_d[i] = S_FREE;
    end else begin
      if (pop)   st_d[head_ptr] = S_FREE;
      if (do_if) st_d[ifq_ptr]  = S_DECODE;
      if (do_id) st_d[idq_ptr]  = S_EXEC;
      if (do_ex) st_d[exq_ptr]  = ex_pass_through ? S_DONE : S_WBACK;
      if (do_wb) st_d[wbq_ptr]  = S_DONE;
      // Allocation comes last: when full, it reuses the slot the pop frees.
      if (do_alloc) st_d[alloc_ptr] = S_FETCH;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every process sees start-of-cycle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) st_q[i] <= S_FREE;
      cnt_q     <= '0;
      alloc_ptr <= '0;
      ifq_ptr   <= '0;
      idq_ptr   <= '0;
      exq_ptr   <= '0;
      head_ptr  <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_q + TS_WIDTH'(1);
      if (flush) begin
        alloc_ptr <= '0;
        ifq_ptr   <= '0;
        idq_ptr   <= '0;
        exq_ptr   <= '0;
        head_ptr  <= '0;
      end else begin
        if (do_alloc) alloc_ptr <= alloc_ptr + ptr_t'(1);
        if (do_if)    ifq_ptr   <= ifq_ptr + ptr_t'(1);
        if (do_id)    idq_ptr   <= idq_ptr + ptr_t'(1);
        if (do_ex)    exq_ptr   <= exq_ptr + ptr_t'(1);
        if (pop)      head_ptr  <= head_ptr + ptr_t'(1);
        if (if_start && trace_en && full && !pop) overflow <= 1'b1;
        if ((if_end && !do_if) || (id_end && !do_id) || (ex_end && !do_ex) || (wb_end && !do_wb))
          proto_err <= 1'b1;
      end
    end
  end

  // NOTE: payload storage has no reset; entry state alone says whether a slot holds anything.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (do_alloc) begin
        addr_q[alloc_ptr]       <= if_addr;
        ts_q[alloc_ptr][IF_S]   <= cnt_q;
      end
      if (do_if) begin
        instr_q[ifq_ptr]        <= if_instr;
        ts_q[ifq_ptr][IF_E]     <= cnt_q;
        ts_q[ifq_ptr][ID_S]     <= cnt_q;
      end
      if (do_id) begin
        ts_q[idq_ptr][ID_E]     <= cnt_q;
        ts_q[idq_ptr][EX_S]     <= cnt_q;
      end
      if (do_ex) begin
        pt_q[exq_ptr]           <= ex_pass_through;
        ts_q[exq_ptr][EX_E]     <= cnt_q;
        ts_q[exq_ptr][WB_S]     <= cnt_q;
        if (ex_pass_through) ts_q[exq_ptr][WB_E] <= cnt_q;
      end
      if (do_wb) ts_q[wbq_ptr][WB_E] <= cnt_q;
    end
  end

  // Record fields are gated by trace_valid so they read zero when no record is offered.
  always_comb begin
    trace_addr         = '0;
    trace_instr        = '0;
    trace_pass_through = 1'b0;
    trace_ts           = '0;
    if (trace_valid) begin
      trace_addr         = addr_q[head_ptr];
      trace_instr        = instr_q[head_ptr];
      trace_pass_through = pt_q[head_ptr];
      for (int k = 0; k < 8; k++) trace_ts[(7-k)*TS_WIDTH +: TS_WIDTH] = ts_q[head_ptr][k];
    end
  end

endmodule

// File: doc/trace_sequencer.md
Name: trace_sequencer

Overview:
- Collects per-stage timing events from the core pipeline and sequences each instruction through an in-order in-flight table of DEPTH entries.
- Each instruction's addr, instruction word, pass_through flag and IF/ID/EX/WB start/end timestamps are stored in its entry.
- Completed records are emitted in program order on a valid/ready port, in the same field layout as the trace_output record.
- Sits between the core's stage-event taps and the trace sink/FIFO.

Parameters:
- DEPTH, 4, in-flight entries; power of two, 2..16.
- DATA_WIDTH, 32, instruction width (`DATA_WIDTH).
- ADDR_WIDTH, 32, address width (`ADDR_WIDTH).
- TS_WIDTH, 32, timestamp width (integer).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- trace_en  in  1  allow new allocations.
- flush  in  1  synchronous clear of all entries.
- if_start  in  1  fetch issued; allocate an entry.
- if_addr  in  ADDR_WIDTH  fetch address, valid with if_start.
- if_end  in  1  fetch data returned.
- if_instr  in  DATA_WIDTH  instruction, valid with if_end.
- id_end  in  1  decode complete.
- ex_end  in  1  execute complete.
- ex_pass_through  in  1  no WB memory phase; valid with ex_end.
- wb_end  in  1  writeback complete.
- trace_valid  out  1  head record complete.
- trace_ready  in  1  sink accepts.
- trace_addr  out  ADDR_WIDTH  record address.
- trace_instr  out  DATA_WIDTH  record instruction.
- trace_pass_through  out  1  record pass_through flag.
- trace_ts  out  8*TS_WIDTH  {if_s,if_e,id_s,id_e,ex_s,ex_e,wb_s,wb_e}, if_s in the MSBs.
- overflow  out  1  sticky: if_start dropped because the table was full.
- proto_err  out  1  sticky: stage event arrived with no eligible entry.

Behaviour:
- Reset: all outputs 0; cycle counter 0; all pointers 0; all entries invalid.
- Cycle counter:
  - TS_WIDTH bits, increments every cycle, wraps 2^TS_WIDTH-1 -> 0.
  - An event's timestamp is the counter value in the cycle the event is sampled.
- Pointers: alloc_ptr, ifq_ptr, idq_ptr, exq_ptr, wbq_ptr and head_ptr, each mod DEPTH. Every stage event targets the oldest entry waiting for it (in-order).
- Entry life cycle (per-entry state): FETCH -> DECODE -> EXEC -> WBACK -> DONE.
  - if_start: allocate at alloc_ptr; state FETCH; record if_s and addr.
  - if_end: record if_e and instr; id_s = if_e; state DECODE.
  - id_end: record id_e; ex_s = id_e; state EXEC.
  - ex_end: record ex_e and pass_through; wb_s = ex_e.
    - pass_through=1: wb_e = ex_e; state DONE.
    - Otherwise: state WBACK.
  - wb_end: targets the oldest WBACK entry (pass_through entries are skipped); record wb_e; state DONE.
- Eligibility is evaluated on start-of-cycle state only.
  - An entry allocated in cycle N cannot receive if_end before cycle N+1. The same rule applies to every stage.
  - Events for different entries in the same cycle are all applied.
- Allocation:
  - Ignored when trace_en=0; no flag is set.
  - Table full at start of cycle with no pop in that cycle: drop the allocation and set overflow.
  - Full with a simultaneous pop (trace_valid & trace_ready): the allocation is accepted.
- Stage event with no eligible entry: ignored; set proto_err.
- Output:
  - trace_valid = head entry is DONE. Record fields are driven combinationally from the head entry.
  - Once raised, trace_valid stays high and the fields stay stable until trace_ready.
  - On handshake, free the head entry and advance head_ptr. One record per cycle maximum.
- flush:
  - Invalidates all entries, resets all pointers to 0 and deasserts trace_valid next cycle.
  - Has priority over all same-cycle events.
  - Does not clear overflow, proto_err or the counter.
- Sticky flags clear only on rst_n.
- Async reset mid-operation discards all in-flight records immediately.

Test Plan:
- Reset, then if_start addr=0x100 at cnt 5, if_end instr=0x00A00093 at 7, id_end at 8, ex_end pass_through=1 at 9, trace_ready=1 -> one record {0x100, 0x00A00093, pt=1, ts=5,7,7,8,8,9,9,9}, trace_valid high exactly one cycle.
- Memory op: events at 2,4,5,6, pass_through=0, wb_end at 11 -> ts=2,4,4,5,5,6,6,11; trace_valid is not raised before cycle 12.
- Allocate DEPTH=4 entries, hold trace_ready=0, fifth if_start -> dropped, overflow=1. Then complete the head and pulse ready with a sixth if_start in the same cycle -> accepted, overflow stays 1.
- Back-to-back: two instructions, the second pass_through finishing EX before the first's wb_end -> records emerge in program order; wb_end applied to entry 0.
- id_end with empty table -> proto_err=1, no state change. Flush with 3 entries in flight -> trace_valid=0, a subsequent instruction is allocated at entry 0.
- Force the counter to 0xFFFFFFFE via a sequence starting near wrap: if_s=0xFFFFFFFF, if_e=0x00000001 -> raw wrapped values reported unchanged.
